// File: rtl/sme_pkg.sv
// Shared constants and FSM state encoding for the two-requester SME front-end arbiter.
package sme_pkg;

    localparam int NUM_REQ    = 2;
    localparam int STR_MAX    = 32;
    localparam int PAT_MAX    = 8;
    localparam int WDOG_LIMIT = 100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_DRAIN  = 3'd4
    } sme_state_t;

endpackage

// File: rtl/sme_rr_arb.sv
// Two-way round-robin winner select; combinational winner, registered last-served pointer.
// The pointer resets to "requester 1 served last" so requester 0 wins the first tie.
module sme_rr_arb
    import sme_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    input  logic               served,
    output logic [NUM_REQ-1:0] winner,
    output logic               winner_idx
);

    logic last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= served;
        end
    end

    always_comb begin
        winner_idx = 1'b0;
        if (req == 2'b11) begin
            winner_idx = ~last;
        end else if (req[1]) begin
            winner_idx = 1'b1;
        end
        winner = '0;
        if (|req) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sme_arbiter.sv
// Arbitrates two requesters onto one SME engine stream; stream delayed one cycle, result within 102 cycles of pattern end.
// No backpressure: requesters hold req until done or abort, results are returned as a one-cycle done pulse.
module sme_arbiter
    import sme_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [7:0]  char0,
    input  logic [7:0]  char1,
    input  logic [1:0]  isstr,
    input  logic [1:0]  ispat,
    output logic [7:0]  sme_chardata,
    output logic        sme_isstring,
    output logic        sme_ispattern,
    input  logic        sme_valid,
    input  logic        sme_match,
    input  logic [4:0]  sme_index,
    output logic [1:0]  done,
    output logic        res_match,
    output logic [4:0]  res_index,
    output logic        res_err
);

    sme_state_t state;
    logic       owner;
    logic [5:0] str_cnt;
    logic [3:0] pat_cnt;
    logic [7:0] wdog;
    logic       err;
    logic       pat_seen;

    logic [1:0] arb_winner;
    logic       arb_idx;

    logic       own_req;
    logic [7:0] own_char;
    logic       own_str;
    logic       own_pat;
    logic       str_ok;
    logic       pat_ok;
    logic       wdog_expired;

    sme_rr_arb u_rr_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .update     (state == ST_DONE),
        .served     (owner),
        .winner     (arb_winner),
        .winner_idx (arb_idx)
    );

    always_comb begin
        own_req      = req[owner];
        own_char     = owner ? char1 : char0;
        own_str      = isstr[owner];
        own_pat      = ispat[owner];
        str_ok       = own_str && (str_cnt < 6'(STR_MAX));
        pat_ok       = own_pat && (pat_cnt < 4'(PAT_MAX));
        wdog_expired = (wdog == 8'(WDOG_LIMIT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
            gnt           <= '0;
            done          <= '0;
            res_match     <= 1'b0;
            res_index     <= '0;
            res_err       <= 1'b0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            str_cnt       <= '0;
            pat_cnt       <= '0;
            wdog          <= '0;
            err           <= 1'b0;
            pat_seen      <= 1'b0;
        end else begin
            // Pulse-style outputs default low; only the cases below raise them.
            done          <= '0;
            res_match     <= 1'b0;
            res_index     <= '0;
            res_err       <= 1'b0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt      <= arb_winner;
                        owner    <= arb_idx;
                        str_cnt  <= '0;
                        pat_cnt  <= '0;
                        err      <= 1'b0;
                        pat_seen <= 1'b0;
                        state    <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (!own_req) begin
                        gnt   <= '0;
                        wdog  <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        if (str_ok) begin
                            str_cnt <= str_cnt + 6'd1;
                        end
                        if (pat_ok) begin
                            pat_cnt <= pat_cnt + 4'd1;
                        end
                        if ((own_str && !str_ok) || (own_pat && !pat_ok)) begin
                            err <= 1'b1;
                        end
                        if (own_pat) begin
                            pat_seen <= 1'b1;
                        end
                        // Stream stays registered-zero on the cycle we leave for WAIT.
                        if (pat_seen && !own_pat) begin
                            wdog  <= '0;
                            state <= ST_WAIT;
                        end else begin
                            sme_chardata  <= own_char;
                            sme_isstring  <= str_ok;
                            sme_ispattern <= pat_ok;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!own_req) begin
                        gnt   <= '0;
                        wdog  <= '0;
                        state <= ST_DRAIN;
                    end else if (sme_valid) begin
                        done      <= gnt;
                        res_match <= sme_match;
                        res_index <= sme_index;
                        res_err   <= err;
                        state     <= ST_DONE;
                    end else if (wdog_expired) begin
                        done    <= gnt;
                        res_err <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end

                ST_DONE: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end

                ST_DRAIN: begin
                    if (sme_valid || wdog_expired) begin
                        state <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end

                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_arbiter.sv
// Bench for sme_arbiter: job-level reference model checked every cycle, directed scenarios, then random traffic.
module tb_sme_arbiter;

    localparam int SMAX = 32;
    localparam int PMAX = 8;
    localparam int WD   = 100;

    localparam int P_IDLE   = 0;
    localparam int P_STREAM = 1;
    localparam int P_WAIT   = 2;
    localparam int P_DONE   = 3;
    localparam int P_DRAIN  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [7:0] char0;
    logic [7:0] char1;
    logic [1:0] isstr;
    logic [1:0] ispat;
    logic [7:0] sme_chardata;
    logic       sme_isstring;
    logic       sme_ispattern;
    logic       sme_valid;
    logic       sme_match;
    logic [4:0] sme_index;
    logic [1:0] done;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_err;

    sme_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .gnt           (gnt),
        .char0         (char0),
        .char1         (char1),
        .isstr         (isstr),
        .ispat         (ispat),
        .sme_chardata  (sme_chardata),
        .sme_isstring  (sme_isstring),
        .sme_ispattern (sme_ispattern),
        .sme_valid     (sme_valid),
        .sme_match     (sme_match),
        .sme_index     (sme_index),
        .done          (done),
        .res_match     (res_match),
        .res_index     (res_index),
        .res_err       (res_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Job-level model: who owns the engine, what has been forwarded, when the wait began.
    int m_phase;
    int m_owner;
    int m_last;
    int m_nstr;
    int m_npat;
    int m_cyc = 0;
    int m_first;
    bit m_err;
    bit m_seen;

    logic [1:0] e_gnt;
    logic [1:0] e_done;
    logic [7:0] e_chr;
    logic       e_isstr;
    logic       e_ispat;
    logic       e_match;
    logic [4:0] e_idx;
    logic       e_err;

    int         obs_isstr_cnt;
    int         obs_done_cnt;
    logic [1:0] obs_done;
    logic       obs_match;
    logic [4:0] obs_idx;
    logic       obs_err;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_owner = 0;
        m_last  = 1;
        m_nstr  = 0;
        m_npat  = 0;
        m_first = 0;
        m_err   = 1'b0;
        m_seen  = 1'b0;
        e_gnt   = '0;
        e_done  = '0;
        e_chr   = '0;
        e_isstr = 1'b0;
        e_ispat = 1'b0;
        e_match = 1'b0;
        e_idx   = '0;
        e_err   = 1'b0;
    endfunction

    function automatic void model_step();
        bit         s;
        bit         p;
        bit         fs;
        bit         fp;
        logic [7:0] c;
        m_cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        e_done  = '0;
        e_match = 1'b0;
        e_idx   = '0;
        e_err   = 1'b0;
        e_chr   = '0;
        e_isstr = 1'b0;
        e_ispat = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
                    else              m_owner = req[1] ? 1 : 0;
                    e_gnt   = 2'(1 << m_owner);
                    m_phase = P_STREAM;
                    m_nstr  = 0;
                    m_npat  = 0;
                    m_err   = 1'b0;
                    m_seen  = 1'b0;
                end
            end
            P_STREAM: begin
                if (!req[m_owner]) begin
                    e_gnt   = '0;
                    m_phase = P_DRAIN;
                    m_first = m_cyc + 1;
                end else begin
                    c  = (m_owner == 1) ? char1 : char0;
                    s  = isstr[m_owner];
                    p  = ispat[m_owner];
                    fs = s && (m_nstr < SMAX);
                    fp = p && (m_npat < PMAX);
                    if (fs) m_nstr++;
                    if (fp) m_npat++;
                    if ((s && !fs) || (p && !fp)) m_err = 1'b1;
                    if (m_seen && !p) begin
                        m_phase = P_WAIT;
                        m_first = m_cyc + 1;
                    end else begin
                        e_chr   = c;
                        e_isstr = fs;
                        e_ispat = fp;
                    end
                    if (p) m_seen = 1'b1;
                end
            end
            P_WAIT: begin
                if (!req[m_owner]) begin
                    e_gnt   = '0;
                    m_phase = P_DRAIN;
                    m_first = m_cyc + 1;
                end else if (sme_valid) begin
                    e_done  = e_gnt;
                    e_match = sme_match;
                    e_idx   = sme_index;
                    e_err   = m_err;
                    m_phase = P_DONE;
                end else if (m_cyc - m_first == WD - 1) begin
                    e_done  = e_gnt;
                    e_err   = 1'b1;
                    m_phase = P_DONE;
                end
            end
            P_DONE: begin
                e_gnt   = '0;
                m_last  = m_owner;
                m_phase = P_IDLE;
            end
            default: begin
                if (sme_valid || (m_cyc - m_first == WD - 1)) m_phase = P_IDLE;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, m_cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        check("gnt", 16'(gnt), 16'(e_gnt));
        check("done", 16'(done), 16'(e_done));
        check("stream", 16'({sme_chardata, sme_isstring, sme_ispattern}), 16'({e_chr, e_isstr, e_ispat}));
        check("result", 16'({res_match, res_index, res_err}), 16'({e_match, e_idx, e_err}));
        if (sme_isstring) obs_isstr_cnt++;
        if (done != 2'b00) begin
            obs_done_cnt++;
            obs_done  = done;
            obs_match = res_match;
            obs_idx   = res_index;
            obs_err   = res_err;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_lane(input int r, input logic [7:0] c, input logic s, input logic p);
        if (r == 0) begin
            char0    = c;
            isstr[0] = s;
            ispat[0] = p;
        end else begin
            char1    = c;
            isstr[1] = s;
            ispat[1] = p;
        end
    endtask

    // Call with the grant already visible; returns at the first WAIT cycle.
    task automatic stream_job(input int r, input string s, input string p);
        for (int i = 0; i < s.len(); i++) begin
            set_lane(r, s[i], 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < p.len(); i++) begin
            set_lane(r, p[i], 1'b0, 1'b1);
            tick();
        end
        set_lane(r, 8'h00, 1'b0, 1'b0);
        tick();
    endtask

    task automatic respond(input int delay, input logic m, input logic [4:0] idx);
        repeat (delay) tick();
        sme_valid = 1'b1;
        sme_match = m;
        sme_index = idx;
        tick();
        sme_valid = 1'b0;
        sme_match = 1'b0;
        sme_index = '0;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        req       = '0;
        char0     = '0;
        char1     = '0;
        isstr     = '0;
        ispat     = '0;
        sme_valid = 1'b0;
        sme_match = 1'b0;
        sme_index = '0;
        obs_isstr_cnt = 0;
        obs_done_cnt  = 0;
        model_reset();
        tick();
        tick();
        check("reset_outputs", 16'({gnt, done, sme_chardata, sme_isstring, sme_ispattern}), 16'd0);
        reset = 1'b0;
        tick();

        // Both request after reset: requester 0 first, then alternation.
        req = 2'b11;
        set_lane(1, 8'h7a, 1'b1, 1'b1);
        tick();
        check("rr_first_gnt", 16'(gnt), 16'h0001);
        stream_job(0, "abcde", "cd");
        respond(3, 1'b1, 5'd2);
        check("abcde_done", 16'(done), 16'h0001);
        check("abcde_match", 16'(res_match), 16'h0001);
        check("abcde_index", 16'(res_index), 16'h0002);
        check("abcde_err", 16'(res_err), 16'h0000);
        set_lane(1, 8'h00, 1'b0, 1'b0);
        tick();
        check("gnt_clear_after_done", 16'(gnt), 16'h0000);
        tick();
        check("rr_second_gnt", 16'(gnt), 16'h0002);
        stream_job(1, "xy", "y");
        respond(0, 1'b0, 5'd5);
        check("rr_second_done", 16'(done), 16'h0002);
        tick();
        tick();
        check("rr_third_gnt", 16'(gnt), 16'h0001);
        stream_job(0, "", "q");
        respond(1, 1'b0, 5'd0);
        req = 2'b00;
        tick();
        tick();

        // Over-length string: only 32 string chars reach the engine.
        req = 2'b10;
        tick();
        check("long_gnt", 16'(gnt), 16'h0002);
        obs_isstr_cnt = 0;
        stream_job(1, "abcdefghijklmnopqrstuvwxyz01234567", "abc");
        check("long_isstr_cnt", 16'(obs_isstr_cnt), 16'd32);
        respond(2, 1'b1, 5'd7);
        check("long_done", 16'(done), 16'h0002);
        check("long_err", 16'(res_err), 16'h0001);
        req = 2'b00;
        tick();
        tick();

        // Engine never answers: watchdog completes the job.
        req = 2'b01;
        tick();
        stream_job(0, "ab", "b");
        obs_done_cnt = 0;
        n = 0;
        while (obs_done_cnt == 0 && n < 150) begin
            tick();
            n++;
        end
        check("wdog_latency", 16'(n), 16'd100);
        check("wdog_result", 16'({obs_match, obs_idx, obs_err}), 16'h0001);
        req = 2'b00;
        tick();
        tick();

        // Abort mid-string, stale result discarded, other requester then served.
        req = 2'b01;
        tick();
        set_lane(0, 8'h61, 1'b1, 1'b0);
        tick();
        set_lane(0, 8'h62, 1'b1, 1'b0);
        tick();
        req = 2'b00;
        set_lane(0, 8'h00, 1'b0, 1'b0);
        obs_done_cnt = 0;
        tick();
        check("abort_gnt", 16'(gnt), 16'h0000);
        tick();
        tick();
        sme_valid = 1'b1;
        sme_match = 1'b1;
        tick();
        sme_valid = 1'b0;
        sme_match = 1'b0;
        req = 2'b10;
        tick();
        check("after_abort_gnt", 16'(gnt), 16'h0002);
        stream_job(1, "hi", "h");
        respond(0, 1'b1, 5'd3);
        check("after_abort_done_cnt", 16'(obs_done_cnt), 16'd1);
        check("after_abort_done", 16'(done), 16'h0002);
        req = 2'b00;
        tick();
        tick();

        // Reset while waiting for the engine.
        req = 2'b01;
        tick();
        stream_job(0, "ab", "a");
        tick();
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("reset_in_wait", 16'({gnt, done, sme_chardata, sme_isstring, sme_ispattern}), 16'd0);
        check("reset_in_wait_res", 16'({res_match, res_index, res_err}), 16'd0);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_gnt", 16'(gnt), 16'h0001);
        stream_job(0, "q", "q");
        respond(0, 1'b1, 5'd9);
        check("post_reset_done", 16'({done, res_index}), 16'({2'b01, 5'd9}));
        req = 2'b00;
        tick();
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 19) == 0) req[1] = ~req[1];
            char0     = 8'($urandom);
            char1     = 8'($urandom);
            isstr[0]  = 1'($urandom_range(0, 1));
            isstr[1]  = 1'($urandom_range(0, 1));
            ispat[0]  = ($urandom_range(0, 3) == 0);
            ispat[1]  = ($urandom_range(0, 3) == 0);
            sme_valid = ($urandom_range(0, 7) == 0);
            sme_match = 1'($urandom);
            sme_index = 5'($urandom);
            reset     = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset     = 1'b0;
        req       = '0;
        isstr     = '0;
        ispat     = '0;
        sme_valid = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
